adam_mem_arb: RTL and testbench

- Arbitrates one single-port adam_mem (req/addr/we/be/wdata/rdata, 1-cycle read latency) among NO_REQS memory-style requesters. Typical users: adam_axil_to_mem instances, a DMA, a debug path.
- Round-robin arbitration with a bounded burst: the current owner may keep the memory for up to MAX_BURST consecutive grants before it must rotate.
- Sits between requester-side mem interfaces and one adam_mem instance, in the same clock domain as that memory.

---
 rtl/adam_mem_arb_pkg.sv | 17 +
 rtl/adam_rr_pick.sv | 36 +++
 rtl/adam_mem_arb.sv | 124 ++++++++++++
 tb/tb_adam_mem_arb.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adam_mem_arb_pkg.sv
// Shared helpers for the adam memory arbiter and its round-robin picker.
// Holds the winner classification used to steer the arbiter state update.
package adam_mem_arb_pkg;

    // How the winner of the current cycle was chosen.
    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_BURST,
        WIN_ROTATE
    } win_kind_e;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adam_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping around. Reusable by any arbiter that keeps its own pointer.
module adam_rr_pick
    import adam_mem_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin : pick
        int j;
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/adam_mem_arb.sv
// Round-robin arbiter with bounded bursts in front of one single-port adam_mem.
// Grant is combinational; the response strobe follows the grant by one cycle.
module adam_mem_arb
    import adam_mem_arb_pkg::*;
#(
    parameter int NO_REQS    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,

    input  logic [NO_REQS-1:0]                     req_req_i,
    output logic [NO_REQS-1:0]                     req_gnt_o,
    input  logic [NO_REQS-1:0][ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NO_REQS-1:0]                     req_we_i,
    input  logic [NO_REQS-1:0][DATA_WIDTH/8-1:0]   req_be_i,
    input  logic [NO_REQS-1:0][DATA_WIDTH-1:0]     req_wdata_i,
    output logic [NO_REQS-1:0]                     req_rvalid_o,
    output logic [NO_REQS-1:0][DATA_WIDTH-1:0]     req_rdata_o,

    output logic                                   mem_req_o,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i
);

    localparam int            IW        = idx_width(NO_REQS);
    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST      = IW'(NO_REQS - 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    logic [IW-1:0]      own_q, own_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NO_REQS-1:0] rvalid_q;

    logic [IW-1:0]      ptr;
    logic [NO_REQS-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic [NO_REQS-1:0] gnt;
    win_kind_e          kind;

    // Search starts just past the last owner, so the owner itself is tried last.
    assign ptr = (own_q == LAST) ? '0 : own_q + IW'(1);

    adam_rr_pick #(
        .N (NO_REQS)
    ) u_pick (
        .req_i   (req_req_i),
        .ptr_i   (ptr),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // A zero count means no run is in progress, so an idle cycle forces rotation.
    always_comb begin
        kind  = WIN_NONE;
        gnt   = '0;
        own_d = own_q;
        cnt_d = cnt_q;
        if (rst_i) begin
            kind = WIN_NONE;
        end else if (req_req_i[own_q] && (cnt_q != '0) && (cnt_q < BURST_MAX)) begin
            kind = WIN_BURST;
        end else if (pick_valid) begin
            kind = WIN_ROTATE;
        end

        case (kind)
            WIN_BURST: begin
                gnt[own_q] = 1'b1;
                cnt_d      = cnt_q + CW'(1);
            end
            WIN_ROTATE: begin
                gnt   = pick_gnt;
                own_d = pick_idx;
                cnt_d = CW'(1);
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        for (int i = 0; i < NO_REQS; i++) begin
            if (gnt[i]) begin
                mem_addr_o  = req_addr_i[i];
                mem_we_o    = req_we_i[i];
                mem_be_o    = req_be_i[i];
                mem_wdata_o = req_wdata_i[i];
            end
        end
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            own_q    <= LAST;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            own_q    <= own_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
        end
    end

    assign req_gnt_o    = gnt;
    assign mem_req_o    = |gnt;
    // Masked so a grant taken just before reset never shows up as a response during reset.
    assign req_rvalid_o = rst_i ? '0 : rvalid_q;
    assign req_rdata_o  = {NO_REQS{mem_rdata_i}};

endmodule

// File: tb/tb_adam_mem_arb.sv
// Bench for adam_mem_arb: directed tables for the documented scenarios plus
// randomized traffic compared against a rule-level arbitration/memory model.
module tb_adam_mem_arb;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int MB  = 4;
    localparam int NB  = 3;
    localparam int MBB = 1;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
    } vec_t;

    typedef struct {
        logic [NB-1:0] req;
        logic [NB-1:0] gnt;
    } vec3_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: two requesters, bursts of four.
    logic [N-1:0]         req, gnt, rvalid, we;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0][SW-1:0] be;
    logic [N-1:0][DW-1:0] wdata, rdata;
    logic                 mem_req, mem_we;
    logic [AW-1:0]        mem_addr;
    logic [SW-1:0]        mem_be;
    logic [DW-1:0]        mem_wdata, mem_rdata;

    // Instance B: three requesters, pure round-robin.
    logic [NB-1:0]         b_req, b_gnt, b_rvalid, b_we;
    logic [NB-1:0][AW-1:0] b_addr;
    logic [NB-1:0][SW-1:0] b_be;
    logic [NB-1:0][DW-1:0] b_wdata, b_rdata;
    logic                  b_mem_req, b_mem_we;
    logic [AW-1:0]         b_mem_addr;
    logic [SW-1:0]         b_mem_be;
    logic [DW-1:0]         b_mem_wdata, b_mem_rdata;

    assign b_we        = '0;
    assign b_addr      = '0;
    assign b_be        = '0;
    assign b_wdata     = '0;
    assign b_mem_rdata = '0;

    adam_mem_arb #(
        .NO_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
    ) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_req_i(req), .req_gnt_o(gnt), .req_addr_i(addr), .req_we_i(we),
        .req_be_i(be), .req_wdata_i(wdata), .req_rvalid_o(rvalid), .req_rdata_o(rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    adam_mem_arb #(
        .NO_REQS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MBB)
    ) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_req_i(b_req), .req_gnt_o(b_gnt), .req_addr_i(b_addr), .req_we_i(b_we),
        .req_be_i(b_be), .req_wdata_i(b_wdata), .req_rvalid_o(b_rvalid), .req_rdata_o(b_rdata),
        .mem_req_o(b_mem_req), .mem_addr_o(b_mem_addr), .mem_we_o(b_mem_we),
        .mem_be_o(b_mem_be), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
    );

    // Single-port memory behind instance A, with a bench-side preload port.
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    logic [31:0] mem [64];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < SW; b++) begin
                    if (mem_be[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
            mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [N-1:0]  prev_g;
    logic [NB-1:0] prev_gb;
    logic [31:0] model_mem [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant/mem_req/rvalid checks for one cycle of instance A.
    task automatic step_a(input string name, input logic [N-1:0] exp_g);
        check({name, "_gnt"}, 64'(gnt), 64'(exp_g));
        check({name, "_mem_req"}, 64'(mem_req), 64'(|exp_g));
        check({name, "_rvalid"}, 64'(rvalid), 64'(prev_g));
        prev_g = exp_g;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = 6'(idx);
        pl_val = val;
        tick();
        pl_en  = 1'b0;
    endtask

    task automatic reset_phase(input int n);
        rst = 1'b1;
        repeat (n) begin
            #3;
            check("rst_gnt", 64'(gnt), 64'(0));
            check("rst_mem_req", 64'(mem_req), 64'(0));
            check("rst_rvalid", 64'(rvalid), 64'(0));
            check("rst_b_gnt", 64'(b_gnt), 64'(0));
            tick();
        end
        rst     = 1'b0;
        prev_g  = '0;
        prev_gb = '0;
    endtask

    // Arbitration rules: continue a live run below the burst limit, otherwise
    // take the first requester after the last owner, the owner itself last.
    function automatic int predict(input logic [N-1:0] r, input int own, input int run);
        if (r == '0) return -1;
        if (r[own] && run > 0 && run < MB) return own;
        for (int k = 1; k <= N; k++) begin
            if (r[(own + k) % N]) return (own + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    vec_t  t2 [10];
    vec_t  t6 [5];
    vec_t  t5 [6];
    vec3_t t3 [9];

    initial begin
        int          own_m, run_m, w, prev_w, ix;
        logic        prev_rd;
        logic [31:0] exp_rd, v;

        for (int i = 0; i < 10; i++) t2[i] = '{2'b11, ((i % 8) < 4) ? 2'b01 : 2'b10};
        for (int i = 0; i < 5; i++)  t6[i] = '{2'b11, (i < 4) ? 2'b01 : 2'b10};
        t5[0] = '{2'b01, 2'b01};
        t5[1] = '{2'b11, 2'b01};
        t5[2] = '{2'b01, 2'b01};
        t5[3] = '{2'b01, 2'b01};
        t5[4] = '{2'b01, 2'b01};
        t5[5] = '{2'b00, 2'b00};
        for (int i = 0; i < 6; i++) t3[i] = '{3'b111, 3'(1 << (i % 3))};
        for (int i = 6; i < 9; i++) t3[i] = '{3'b100, 3'b100};

        rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        req = '0; we = '0; addr = '0; be = '0; wdata = '0; b_req = '0;
        prev_g = '0; prev_gb = '0;
        tick();

        // Single requester read.
        preload(4, 32'hDEADBEEF);
        reset_phase(2);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; be[0] = '1;
        #3;
        step_a("t1_c0", 2'b01);
        check("t1_mem_addr", 64'(mem_addr), 64'h10);
        tick();
        req = '0;
        #3;
        step_a("t1_c1", 2'b00);
        check("t1_rdata", 64'(rdata[0]), 64'hDEADBEEF);
        tick();

        // Both requesters streaming from reset, then reset mid-burst.
        reset_phase(1);
        addr[0] = 32'h40; addr[1] = 32'h44; we = '0;
        for (int i = 0; i < 10; i++) begin
            req = t2[i].req;
            #3;
            step_a($sformatf("t2_%0d", i), t2[i].gnt);
            tick();
        end
        reset_phase(2);
        for (int i = 0; i < 5; i++) begin
            req = t6[i].req;
            #3;
            step_a($sformatf("t6_%0d", i), t6[i].gnt);
            tick();
        end
        req = '0;

        // Partial write by requester 0, read back by requester 1.
        rst = 1'b1;
        preload(8, 32'hAABBCCDD);
        reset_phase(1);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; be[0] = 4'b0011; wdata[0] = 32'h12345678;
        #3;
        step_a("t4_wr", 2'b01);
        check("t4_mem_we", 64'(mem_we), 64'(1));
        check("t4_mem_be", 64'(mem_be), 64'(4'b0011));
        check("t4_mem_wdata", 64'(mem_wdata), 64'h12345678);
        tick();
        req = '0; we = '0;
        req[1] = 1'b1; addr[1] = 32'h20; be[1] = '1;
        #3;
        step_a("t4_rd", 2'b10);
        check("t4_rd_we", 64'(mem_we), 64'(0));
        tick();
        req = '0;
        #3;
        step_a("t4_done", 2'b00);
        check("t4_rdata", 64'(rdata[1]), 64'hAABB5678);
        tick();

        // Requester 1 withdraws before it is ever granted.
        reset_phase(1);
        addr[0] = 32'h40; addr[1] = 32'h48; we = '0;
        for (int i = 0; i < 6; i++) begin
            req = t5[i].req;
            #3;
            step_a($sformatf("t5_%0d", i), t5[i].gnt);
            if (i < 5) check($sformatf("t5_addr_%0d", i), 64'(mem_addr), 64'h40);
            tick();
        end

        // Three requesters, pure round-robin, then a lone requester.
        reset_phase(1);
        for (int i = 0; i < 9; i++) begin
            b_req = t3[i].req;
            #3;
            check($sformatf("t3_gnt_%0d", i), 64'(b_gnt), 64'(t3[i].gnt));
            check($sformatf("t3_mem_req_%0d", i), 64'(b_mem_req), 64'(1));
            check($sformatf("t3_rvalid_%0d", i), 64'(b_rvalid), 64'(prev_gb));
            prev_gb = t3[i].gnt;
            tick();
        end
        b_req = '0;

        // Randomized traffic against the rule-level model.
        rst = 1'b1;
        for (int k = 16; k < 32; k++) begin
            v = $urandom;
            model_mem[k] = v;
            preload(k, v);
        end
        reset_phase(1);
        own_m = N - 1; run_m = 0; prev_w = -1; prev_rd = 1'b0; exp_rd = '0;
        req = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[i]   = 1'b1;
                        addr[i]  = {24'd0, 2'b01, 4'($urandom_range(0, 15)), 2'b00};
                        we[i]    = 1'($urandom_range(0, 1));
                        be[i]    = 4'($urandom);
                        wdata[i] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            w = predict(req, own_m, run_m);
            #3;
            step_a("rnd", oh(w));
            if (w >= 0) begin
                check("rnd_mem_addr", 64'(mem_addr), 64'(addr[w]));
                check("rnd_mem_we", 64'(mem_we), 64'(we[w]));
                if (we[w]) begin
                    check("rnd_mem_be", 64'(mem_be), 64'(be[w]));
                    check("rnd_mem_wdata", 64'(mem_wdata), 64'(wdata[w]));
                end
            end
            if (prev_w >= 0 && prev_rd) check("rnd_rdata", 64'(rdata[prev_w]), 64'(exp_rd));
            prev_w  = w;
            prev_rd = 1'b0;
            if (w >= 0) begin
                ix = int'(addr[w][7:2]);
                if (we[w]) begin
                    for (int b = 0; b < SW; b++) begin
                        if (be[w][b]) model_mem[ix][b*8 +: 8] = wdata[w][b*8 +: 8];
                    end
                end else begin
                    prev_rd = 1'b1;
                    exp_rd  = model_mem[ix];
                end
                if (w == own_m && run_m > 0 && run_m < MB) begin
                    run_m++;
                end else begin
                    own_m = w;
                    run_m = 1;
                end
            end else begin
                run_m = 0;
            end
            tick();
            if (w >= 0) req[w] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
